// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: widths, reset vector, NOP, RUN/SLOT encoding.
// No logic; imported by fetch_unit and fetch_pc_pair.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0100_0000;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
  localparam logic [ADDR_W-1:0]  RESET_NPC = 8'h04;

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/fetch_pc_pair.sv
// PC/nPC register pair with the +4 sequencer; one-cycle update, holds when en=0.
// The target is word-aligned by the caller; arithmetic wraps modulo 256.
module fetch_pc_pair
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_target,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      npc <= RESET_NPC;
    end else if (en) begin
      pc  <= npc;
      npc <= load_target ? target : npc + ADDR_W'(4);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Delayed-branch fetch stage with IF/ID register; FETCH_ANNUL_EN enables delay-slot annul.
// One-cycle fetch latency; LE=0 stalls every register, requesters hold inputs until LE=1.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               Clk,
  input  logic               R,
  input  logic               LE,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  target,
  input  logic               annul,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  PC_Out,
  output logic [ADDR_W-1:0]  nPC_Out,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [ADDR_W-1:0]  IF_ID_pc,
  output logic               IF_ID_valid,
  output logic               align_err,
  output logic               dcti_err
);
  fetch_state_t      state;
  if_id_t            if_id;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              take_redirect;

  // A redirect arriving in SLOT is a DCTI couple and is dropped.
  assign take_redirect = (state == RUN) && redirect;

  fetch_pc_pair u_pc_pair (
    .clk         (Clk),
    .rst         (R),
    .en          (LE),
    .load_target (take_redirect),
    .target      ({target[ADDR_W-1:2], 2'b00}),
    .pc          (pc),
    .npc         (npc)
  );

`ifdef FETCH_ANNUL_EN
  logic annul_pending;
`else
  logic unused_annul;
  assign unused_annul = annul;
`endif

  always_ff @(posedge Clk) begin
    if (R) begin
      state     <= RUN;
      if_id     <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
      align_err <= 1'b0;
      dcti_err  <= 1'b0;
`ifdef FETCH_ANNUL_EN
      annul_pending <= 1'b0;
`endif
    end else if (LE) begin
      if_id.instr <= imem_data;
      if_id.pc    <= pc;
      if_id.valid <= 1'b1;
      if (state == RUN) begin
        if (redirect) begin
          state <= SLOT;
          if (target[1:0] != 2'b00) align_err <= 1'b1;
`ifdef FETCH_ANNUL_EN
          annul_pending <= annul;
`endif
        end
      end else begin
        state <= RUN;
        if (redirect) dcti_err <= 1'b1;
`ifdef FETCH_ANNUL_EN
        // Squashed slot still advances PC/nPC; only the payload is replaced.
        if (annul_pending) begin
          if_id.instr <= NOP_INSTR;
          if_id.valid <= 1'b0;
        end
        annul_pending <= 1'b0;
`endif
      end
    end
  end

  assign imem_addr   = pc;
  assign PC_Out      = pc;
  assign nPC_Out     = npc;
  assign IF_ID_instr = if_id.instr;
  assign IF_ID_pc    = if_id.pc;
  assign IF_ID_valid = if_id.valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; instruction memory returns {24'hC0DE00, addr}.
module tb_fetch_unit;
  logic        Clk = 1'b0;
  logic        R = 1'b1;
  logic        LE = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  target = 8'h00;
  logic        annul = 1'b0;
  logic [31:0] imem_data;
  logic [7:0]  imem_addr, PC_Out, nPC_Out, IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid, align_err, dcti_err;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .Clk(Clk), .R(R), .LE(LE), .redirect(redirect), .target(target), .annul(annul),
    .imem_data(imem_data), .imem_addr(imem_addr), .PC_Out(PC_Out), .nPC_Out(nPC_Out),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc(IF_ID_pc), .IF_ID_valid(IF_ID_valid),
    .align_err(align_err), .dcti_err(dcti_err)
  );

  always #5 Clk = ~Clk;
  assign imem_data = {24'hC0DE00, imem_addr};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1; LE = 1'b0; redirect = 1'b0; annul = 1'b0; target = 8'h00;
    step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1; LE = 1'b1; redirect = 1'b1; annul = 1'b1; target = 8'h42;
    step();
    total++;
    if ({PC_Out, nPC_Out, imem_addr} !== {8'h00, 8'h04, 8'h00}) begin
      bad++; $display("FAIL reset_pc got %h/%h/%h want 00/04/00", PC_Out, nPC_Out, imem_addr);
    end
    total++;
    if ({IF_ID_instr, IF_ID_pc, IF_ID_valid} !== {32'h0100_0000, 8'h00, 1'b0}) begin
      bad++; $display("FAIL reset_ifid got %h/%h/%b want 01000000/00/0", IF_ID_instr, IF_ID_pc, IF_ID_valid);
    end
    total++;
    if ({align_err, dcti_err} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got %b%b want 00", align_err, dcti_err);
    end
    R = 1'b0; redirect = 1'b0; annul = 1'b0; target = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({PC_Out, nPC_Out, IF_ID_pc, IF_ID_valid} !== {8'(4*i), 8'(4*i+4), 8'(4*i-4), 1'b1}) begin
        bad++; $display("FAIL reset_seq%0d got pc=%h npc=%h ifpc=%h v=%b want %h %h %h 1",
                        i, PC_Out, nPC_Out, IF_ID_pc, IF_ID_valid, 8'(4*i), 8'(4*i+4), 8'(4*i-4));
      end
    end
    total++;
    if (IF_ID_instr !== 32'hC0DE_0008) begin
      bad++; $display("FAIL reset_instr got %h want c0de0008", IF_ID_instr);
    end
  endtask

  task automatic test_redirect();
    do_reset(); LE = 1'b1;
    step(); step();
    redirect = 1'b1; target = 8'h40;
    step();
    total++;
    if ({PC_Out, nPC_Out, IF_ID_pc, IF_ID_valid} !== {8'h0C, 8'h40, 8'h08, 1'b1}) begin
      bad++; $display("FAIL redir_1 got %h %h %h %b want 0c 40 08 1", PC_Out, nPC_Out, IF_ID_pc, IF_ID_valid);
    end
    redirect = 1'b0;
    step();
    total++;
    if ({PC_Out, nPC_Out, IF_ID_instr, IF_ID_pc} !== {8'h40, 8'h44, 32'hC0DE_000C, 8'h0C}) begin
      bad++; $display("FAIL redir_2 got %h %h %h %h want 40 44 c0de000c 0c", PC_Out, nPC_Out, IF_ID_instr, IF_ID_pc);
    end
    total++;
    if ({align_err, dcti_err} !== 2'b00) begin
      bad++; $display("FAIL redir_flags got %b%b want 00", align_err, dcti_err);
    end
  endtask

  task automatic test_annul();
    do_reset(); LE = 1'b1;
    annul = 1'b1;  // annul without redirect in RUN must do nothing
    step();
    total++;
    if ({IF_ID_valid, IF_ID_instr} !== {1'b1, 32'hC0DE_0000}) begin
      bad++; $display("FAIL annul_run got %b %h want 1 c0de0000", IF_ID_valid, IF_ID_instr);
    end
    annul = 1'b0;
    step();
    redirect = 1'b1; annul = 1'b1; target = 8'h40;
    step();
    redirect = 1'b0; annul = 1'b0;
    step();
`ifdef FETCH_ANNUL_EN
    total++;
    if ({IF_ID_instr, IF_ID_pc, IF_ID_valid} !== {32'h0100_0000, 8'h0C, 1'b0}) begin
      bad++; $display("FAIL annul_slot got %h %h %b want 01000000 0c 0", IF_ID_instr, IF_ID_pc, IF_ID_valid);
    end
`else
    total++;
    if ({IF_ID_instr, IF_ID_pc, IF_ID_valid} !== {32'hC0DE_000C, 8'h0C, 1'b1}) begin
      bad++; $display("FAIL annul_slot got %h %h %b want c0de000c 0c 1", IF_ID_instr, IF_ID_pc, IF_ID_valid);
    end
`endif
    total++;
    if ({PC_Out, nPC_Out} !== {8'h40, 8'h44}) begin
      bad++; $display("FAIL annul_pc got %h %h want 40 44", PC_Out, nPC_Out);
    end
    step();
    total++;
    if ({IF_ID_instr, IF_ID_pc, IF_ID_valid} !== {32'hC0DE_0040, 8'h40, 1'b1}) begin
      bad++; $display("FAIL annul_after got %h %h %b want c0de0040 40 1", IF_ID_instr, IF_ID_pc, IF_ID_valid);
    end
  endtask

  task automatic test_stall();
    do_reset(); LE = 1'b1;
    step(); step();
    LE = 1'b0; redirect = 1'b1; target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({PC_Out, nPC_Out, IF_ID_instr, IF_ID_pc, IF_ID_valid} !== {8'h08, 8'h0C, 32'hC0DE_0004, 8'h04, 1'b1}) begin
        bad++; $display("FAIL stall_%0d got %h %h %h %h %b want 08 0c c0de0004 04 1",
                        i, PC_Out, nPC_Out, IF_ID_instr, IF_ID_pc, IF_ID_valid);
      end
    end
    LE = 1'b1;
    step();
    total++;
    if ({PC_Out, nPC_Out, IF_ID_pc} !== {8'h0C, 8'h80, 8'h08}) begin
      bad++; $display("FAIL stall_release got %h %h %h want 0c 80 08", PC_Out, nPC_Out, IF_ID_pc);
    end
    LE = 1'b0;  // stall in SLOT with redirect held: no dcti error, no movement
    step();
    LE = 1'b1; redirect = 1'b0;
    step();
    total++;
    if ({PC_Out, nPC_Out, dcti_err, align_err} !== {8'h80, 8'h84, 2'b00}) begin
      bad++; $display("FAIL stall_slot got %h %h %b%b want 80 84 00", PC_Out, nPC_Out, dcti_err, align_err);
    end
  endtask

  task automatic test_errors();
    do_reset(); LE = 1'b1;
    step(); step();
    redirect = 1'b1; target = 8'h42;
    step();
    total++;
    if ({nPC_Out, align_err, dcti_err} !== {8'h40, 2'b10}) begin
      bad++; $display("FAIL err_align got %h %b%b want 40 10", nPC_Out, align_err, dcti_err);
    end
    target = 8'h80;  // still redirecting while in SLOT: DCTI couple
    step();
    total++;
    if ({PC_Out, nPC_Out, align_err, dcti_err} !== {8'h40, 8'h44, 2'b11}) begin
      bad++; $display("FAIL err_dcti got %h %h %b%b want 40 44 11", PC_Out, nPC_Out, align_err, dcti_err);
    end
    redirect = 1'b0;
    step(); step(); step();
    total++;
    if ({PC_Out, align_err, dcti_err} !== {8'h4C, 2'b11}) begin
      bad++; $display("FAIL err_sticky got %h %b%b want 4c 11", PC_Out, align_err, dcti_err);
    end
    R = 1'b1;
    step();
    R = 1'b0;
    total++;
    if ({PC_Out, nPC_Out, align_err, dcti_err} !== {8'h00, 8'h04, 2'b00}) begin
      bad++; $display("FAIL err_clear got %h %h %b%b want 00 04 00", PC_Out, nPC_Out, align_err, dcti_err);
    end
  endtask

  task automatic test_wrap();
    do_reset(); LE = 1'b1;
    redirect = 1'b1; target = 8'hFC;
    step();
    redirect = 1'b0;
    step();
    total++;
    if ({PC_Out, nPC_Out, align_err, dcti_err} !== {8'hFC, 8'h00, 2'b00}) begin
      bad++; $display("FAIL wrap got %h %h %b%b want fc 00 00", PC_Out, nPC_Out, align_err, dcti_err);
    end
    redirect = 1'b1; target = 8'h20;  // back-to-back branch right after the slot
    step();
    total++;
    if ({PC_Out, nPC_Out, IF_ID_pc, dcti_err} !== {8'h00, 8'h20, 8'hFC, 1'b0}) begin
      bad++; $display("FAIL wrap_b2b got %h %h %h %b want 00 20 fc 0", PC_Out, nPC_Out, IF_ID_pc, dcti_err);
    end
    redirect = 1'b0;
    step();
    total++;
    if ({PC_Out, nPC_Out, IF_ID_instr} !== {8'h20, 8'h24, 32'hC0DE_0000}) begin
      bad++; $display("FAIL wrap_after got %h %h %h want 20 24 c0de0000", PC_Out, nPC_Out, IF_ID_instr);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_redirect();
    test_annul();
    test_stall();
    test_errors();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
